// File: rtl/gcd_operand_feeder_if.sv
// gcd_operand_feeder_if: operand, core and result signals of the GCD feeder.
// master = feeder side; slave = producer, GCD core and consumer side.
interface gcd_operand_feeder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             gcd_start;
    logic [WIDTH-1:0] gcd_data;
    logic             gcd_done;
    logic [WIDTH-1:0] gcd_result;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_gcd;
    logic             out_err;
    logic             busy;

    modport master (
        input  in_valid, in_a, in_b, gcd_done, gcd_result, out_ready,
        output in_ready, gcd_start, gcd_data, out_valid, out_gcd, out_err,
               busy
    );

    modport slave (
        output in_valid, in_a, in_b, gcd_done, gcd_result, out_ready,
        input  in_ready, gcd_start, gcd_data, out_valid, out_gcd, out_err,
               busy
    );
endinterface

// File: rtl/gcd_operand_feeder.sv
// gcd_operand_feeder: accepts an operand pair, streams A then B to a GCD
// core, waits for gcd_done and returns the core result with a valid/ready
// handshake. Zero operands bypass the core (gcd(x,0) = x).
// Ports: clk, rst (sync, active high); bus (gcd_operand_feeder_if.master):
//   in_valid/in_ready/in_a/in_b   operand pair handshake
//   gcd_start/gcd_data            start level and serial operand bus to core
//   gcd_done/gcd_result           core completion and result
//   out_valid/out_ready/out_gcd/out_err  result handshake; busy = not IDLE
// Optional: `define GCD_TIMEOUT_EN bounds WAIT to TIMEOUT_CYCLES cycles and
// reports an expired wait through out_err.
module gcd_operand_feeder #(
    parameter int WIDTH          = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input logic                  clk,
    input logic                  rst,
    gcd_operand_feeder_if.master bus
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD_A = 3'd1;
    localparam logic [2:0] S_LOAD_B = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_RESP   = 3'd4;

    if (TIMEOUT_CYCLES < 1) begin : g_cfg_check
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    logic [2:0]       state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] gcd_q;

`ifdef GCD_TIMEOUT_EN
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
    logic [CW-1:0] wait_cnt;
    logic          err_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            a_q   <= '0;
            b_q   <= '0;
            gcd_q <= '0;
`ifdef GCD_TIMEOUT_EN
            wait_cnt <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (bus.in_valid) begin
`ifdef GCD_TIMEOUT_EN
                        err_q <= 1'b0;
`endif
                        if (bus.in_a != '0 && bus.in_b != '0) begin
                            a_q   <= bus.in_a;
                            b_q   <= bus.in_b;
                            state <= S_LOAD_A;
                        end else begin
                            // one side zero: the other side is the gcd
                            gcd_q <= bus.in_a | bus.in_b;
                            state <= S_RESP;
                        end
                    end
                end
                S_LOAD_A: state <= S_LOAD_B;
                S_LOAD_B: begin
                    state <= S_WAIT;
`ifdef GCD_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                end
                S_WAIT: begin
                    // done is checked first so it wins over expiry
                    if (bus.gcd_done) begin
                        gcd_q <= bus.gcd_result;
                        state <= S_RESP;
                    end
`ifdef GCD_TIMEOUT_EN
                    else if (wait_cnt == CNT_LAST) begin
                        gcd_q <= '0;
                        err_q <= 1'b1;
                        state <= S_RESP;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
`endif
                end
                S_RESP: begin
                    if (bus.out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.gcd_data = '0;
        unique case (state)
            S_LOAD_A:         bus.gcd_data = a_q;
            S_LOAD_B, S_WAIT: bus.gcd_data = b_q;
            default:          bus.gcd_data = '0;
        endcase
    end

    assign bus.in_ready  = (state == S_IDLE);
    assign bus.busy      = (state != S_IDLE);
    assign bus.out_valid = (state == S_RESP);
    assign bus.gcd_start = (state == S_LOAD_A) || (state == S_LOAD_B) ||
                           (state == S_WAIT);
    assign bus.out_gcd   = gcd_q;

`ifdef GCD_TIMEOUT_EN
    assign bus.out_err = err_q;
`else
    assign bus.out_err = 1'b0;
`endif
endmodule
